wb_arbiter: RTL

Writeback arbiter between the execution pipeline and the register file write port (WE3/AD3/WD3). Merges single-cycle pipeline results with results from long-latency units (load/store, multi-cycle multiply/divide) into the one write port. Long-latency results are buffered in a small FIFO, and a pending-register scoreboard is exposed to the hazard unit. A starvation guard bounds how long a buffered result can wait.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 75 +++++++
 rtl/wb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_pkg : shared constants and writeback entry type for wb_arbiter        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package wb_pkg;

    localparam int c_ADDRESS_WIDTH = 5;
    localparam int c_DATA_WIDTH    = 32;
    localparam int c_FIFO_DEPTH    = 4;
    localparam int c_STARVE_LIMIT  = 8;

    // Buffered long-latency result; field widths follow the package defaults.
    typedef struct packed {
        logic [c_ADDRESS_WIDTH-1:0] rd;
        logic [c_DATA_WIDTH-1:0]    wd;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_fifo : synchronous FIFO of wb_entry_t, count-based full/empty         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = c_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_data,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    wb_entry_t            r_mem_q [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0]   r_rptr_q, w_rptr_d;
    logic [c_CNT_W-1:0]   r_count_q, w_count_d;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full   = (r_count_q == c_FULL_CNT);
    assign o_empty  = (r_count_q == '0);
    assign o_head   = r_mem_q[r_rptr_q];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (w_do_push) begin
            w_wptr_d = r_wptr_q + c_PTR_W'(1);
        end
        if (w_do_pop) begin
            w_rptr_d = r_rptr_q + c_PTR_W'(1);
        end
        if (w_do_push && !w_do_pop) begin
            w_count_d = r_count_q + c_CNT_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_d = r_count_q - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter : merges pipeline and long-latency results onto one RF port   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = c_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int FIFO_DEPTH    = c_FIFO_DEPTH,
    parameter int STARVE_LIMIT  = c_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_we,
    input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
    input  logic [DATA_WIDTH-1:0]    pipe_wd,
    output logic                     pipe_stall,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_wd,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_rd,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     busy_rs1,
    output logic                     busy_rs2,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3
);

    localparam int c_NUM_REGS = 2 ** ADDRESS_WIDTH;
    localparam int c_AGE_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_AGE_W-1:0] c_AGE_MAX = c_AGE_W'(STARVE_LIMIT);

    wb_entry_t                w_lsu_entry;
    wb_entry_t                w_head;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_slot_used;
    logic                     w_push;
    logic                     w_pop;

    logic                     r_we3_q, w_we3_d;
    logic [ADDRESS_WIDTH-1:0] r_ad3_q, w_ad3_d;
    logic [DATA_WIDTH-1:0]    r_wd3_q, w_wd3_d;
    logic [c_NUM_REGS-1:0]    r_pending_q, w_pending_d;
    logic [c_AGE_W-1:0]       r_age_q, w_age_d;
    logic                     r_pipe_stall_q, w_pipe_stall_d;

    assign w_lsu_entry = '{rd: lsu_rd, wd: lsu_wd};
    assign w_slot_used = pipe_we && (pipe_rd != '0);
    assign w_pop       = !w_fifo_empty && !w_slot_used;
    // Writes to x0 still complete the handshake but never occupy an entry.
    assign w_push      = lsu_valid && !w_fifo_full && (lsu_rd != '0);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_lsu_entry),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_we3_d = 1'b0;
        w_ad3_d = '0;
        w_wd3_d = '0;
        if (w_slot_used) begin
            w_we3_d = 1'b1;
            w_ad3_d = pipe_rd;
            w_wd3_d = pipe_wd;
        end else if (w_pop) begin
            w_we3_d = 1'b1;
            w_ad3_d = w_head.rd;
            w_wd3_d = w_head.wd;
        end
    end

    // Set after clear so a re-issue in the retiring cycle keeps the bit.
    always_comb begin
        w_pending_d = r_pending_q;
        if (w_pop) begin
            w_pending_d[w_head.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            w_pending_d[issue_rd] = 1'b1;
        end
    end

    // Age saturates so a misbehaving upstream keeps the stall asserted.
    always_comb begin
        w_age_d = r_age_q;
        if (w_fifo_empty || w_pop) begin
            w_age_d = '0;
        end else if (r_age_q != c_AGE_MAX) begin
            w_age_d = r_age_q + c_AGE_W'(1);
        end
        w_pipe_stall_d = (w_age_d == c_AGE_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3_q        <= 1'b0;
            r_ad3_q        <= '0;
            r_wd3_q        <= '0;
            r_pending_q    <= '0;
            r_age_q        <= '0;
            r_pipe_stall_q <= 1'b0;
        end else begin
            r_we3_q        <= w_we3_d;
            r_ad3_q        <= w_ad3_d;
            r_wd3_q        <= w_wd3_d;
            r_pending_q    <= w_pending_d;
            r_age_q        <= w_age_d;
            r_pipe_stall_q <= w_pipe_stall_d;
        end
    end

    assign WE3        = r_we3_q;
    assign AD3        = r_ad3_q;
    assign WD3        = r_wd3_q;
    assign pipe_stall = r_pipe_stall_q;
    assign lsu_ready  = !w_fifo_full;
    assign busy_rs1   = r_pending_q[rs1] && (rs1 != '0);
    assign busy_rs2   = r_pending_q[rs2] && (rs2 != '0);

    a_no_pipe_we_in_stall : assert property (@(posedge clk) disable iff (!rst_n)
        !(pipe_we && r_pipe_stall_q))
        else $error("wb_arbiter: pipe_we asserted while pipe_stall is high");

    a_no_reissue_pending : assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_valid && (issue_rd != '0) && r_pending_q[issue_rd]
          && !(w_pop && (w_head.rd == issue_rd))))
        else $error("wb_arbiter: issue to a register that is already pending");

endmodule
`default_nettype wire
